// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Address map for the load/store unit. Holds the base and
//               limit (inclusive) of every region, the MMIO register offsets,
//               the region enumeration and the address decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Internal data memory
    localparam logic [31:0] c_dmem_base  = 32'h0000_0000;
    localparam logic [31:0] c_dmem_last  = 32'h0000_3FFF;

    // MMIO block and per-register offsets from its base
    localparam logic [31:0] c_mmio_base  = 32'h0000_7000;
    localparam logic [31:0] c_off_ledr   = 32'h0000_0000;
    localparam logic [31:0] c_off_ledg   = 32'h0000_0010;
    localparam logic [31:0] c_off_hexlo  = 32'h0000_0020;
    localparam logic [31:0] c_off_hexhi  = 32'h0000_0024;
    localparam logic [31:0] c_off_lcd    = 32'h0000_0030;
    localparam logic [31:0] c_off_sw     = 32'h0000_0800;
    localparam logic [31:0] c_off_btn    = 32'h0000_0810;

    localparam logic [31:0] c_ledr_base  = c_mmio_base + c_off_ledr;
    localparam logic [31:0] c_ledr_last  = c_ledr_base + 32'h0000_000F;
    localparam logic [31:0] c_ledg_base  = c_mmio_base + c_off_ledg;
    localparam logic [31:0] c_ledg_last  = c_ledg_base + 32'h0000_000F;
    localparam logic [31:0] c_hexlo_base = c_mmio_base + c_off_hexlo;
    localparam logic [31:0] c_hexlo_last = c_hexlo_base + 32'h0000_0003;
    localparam logic [31:0] c_hexhi_base = c_mmio_base + c_off_hexhi;
    localparam logic [31:0] c_hexhi_last = c_hexhi_base + 32'h0000_0003;
    localparam logic [31:0] c_lcd_base   = c_mmio_base + c_off_lcd;
    localparam logic [31:0] c_lcd_last   = c_lcd_base + 32'h0000_000F;
    localparam logic [31:0] c_sw_base    = c_mmio_base + c_off_sw;
    localparam logic [31:0] c_sw_last    = c_sw_base + 32'h0000_000F;
    localparam logic [31:0] c_btn_base   = c_mmio_base + c_off_btn;
    localparam logic [31:0] c_btn_last   = c_btn_base + 32'h0000_000F;

    // External SRAM window
    localparam logic [31:0] c_sram_base  = 32'h0008_0000;
    localparam logic [31:0] c_sram_last  = 32'h000F_FFFF;

    typedef enum logic [3:0] {
        RGN_NONE  = 4'd0,
        RGN_DMEM  = 4'd1,
        RGN_LEDR  = 4'd2,
        RGN_LEDG  = 4'd3,
        RGN_HEXLO = 4'd4,
        RGN_HEXHI = 4'd5,
        RGN_LCD   = 4'd6,
        RGN_SW    = 4'd7,
        RGN_BTN   = 4'd8,
        RGN_SRAM  = 4'd9
    } region_e;

    // Accesses are word-only, so the byte offset is cleared before the
    // inclusive range compare.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        return (a >= lo) && (a <= hi);
    endfunction

    function automatic region_e decode_region(input logic [31:0] addr);
        region_e r;
        r = RGN_NONE;
        if      (in_range(addr, c_dmem_base,  c_dmem_last))  r = RGN_DMEM;
        else if (in_range(addr, c_ledr_base,  c_ledr_last))  r = RGN_LEDR;
        else if (in_range(addr, c_ledg_base,  c_ledg_last))  r = RGN_LEDG;
        else if (in_range(addr, c_hexlo_base, c_hexlo_last)) r = RGN_HEXLO;
        else if (in_range(addr, c_hexhi_base, c_hexhi_last)) r = RGN_HEXHI;
        else if (in_range(addr, c_lcd_base,   c_lcd_last))   r = RGN_LCD;
        else if (in_range(addr, c_sw_base,    c_sw_last))    r = RGN_SW;
        else if (in_range(addr, c_btn_base,   c_btn_last))   r = RGN_BTN;
        else if (in_range(addr, c_sram_base,  c_sram_last))  r = RGN_SRAM;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Core-side load/store bus.
//               lsu_wren  - store enable for this cycle
//               lsu_addr  - byte address (bits [1:0] ignored)
//               st_data   - store data
//               ld_data   - combinational load data
//               master = core side, slave = load/store unit side.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        lsu_wren;
    logic [31:0] lsu_addr;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    modport master (output lsu_wren, output lsu_addr, output st_data, input ld_data);
    modport slave  (input lsu_wren, input lsu_addr, input st_data, output ld_data);
endinterface
`default_nettype wire

// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem
// Description : Word RAM, synchronous write / asynchronous read. Contents are
//               not reset.
//   i_clk   - clock
//   i_we    - write enable (word at i_addr takes i_wdata on rising edge)
//   i_addr  - word index
//   i_wdata - write data
//   o_rdata - read data, combinational from i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          i_clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [31:0]   i_wdata,
    output logic      [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Word-wide load/store unit. Decodes the bus address into
//               internal DMEM, MMIO registers (LEDs, 7-seg, LCD, switches,
//               buttons) and a 16-bit asynchronous external SRAM window.
//               Stores commit on the rising edge; loads are combinational.
//   i_clk, i_rst        - clock, synchronous active-high reset
//   lsu                 - core load/store bus (slave side)
//   i_io_sw, i_io_btn   - switch and push-button inputs
//   o_io_ledr/ledg      - LED registers
//   o_io_hex0..7        - seven-segment patterns
//   o_io_lcd            - LCD control/data register
//   SRAM_*              - external SRAM pins (controls active low)
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS = 4096
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
    load_store_unit_if.slave   lsu,
    input  wire logic [31:0]   i_io_sw,
    input  wire logic [3:0]    i_io_btn,
    output logic      [31:0]   o_io_ledr,
    output logic      [31:0]   o_io_ledg,
    output logic      [6:0]    o_io_hex0,
    output logic      [6:0]    o_io_hex1,
    output logic      [6:0]    o_io_hex2,
    output logic      [6:0]    o_io_hex3,
    output logic      [6:0]    o_io_hex4,
    output logic      [6:0]    o_io_hex5,
    output logic      [6:0]    o_io_hex6,
    output logic      [6:0]    o_io_hex7,
    output logic      [31:0]   o_io_lcd,
    inout  wire       [15:0]   SRAM_DQ,
    output logic      [17:0]   SRAM_ADDR,
    output logic               SRAM_CE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_UB_N
);

    localparam int c_dmem_aw = $clog2(DMEM_WORDS);

    region_e     w_region;
    logic [31:0] w_dmem_rdata;
    logic [31:0] w_ld_data;
    logic        w_in_sram;
    logic [31:0] r_ledr;
    logic [31:0] r_ledg;
    logic [31:0] r_hex_lo;
    logic [31:0] r_hex_hi;
    logic [31:0] r_lcd;

    assign w_region = decode_region(lsu.lsu_addr);

    lsu_dmem #(
        .DEPTH (DMEM_WORDS)
    ) u_dmem (
        .i_clk   (i_clk),
        .i_we    (lsu.lsu_wren && (w_region == RGN_DMEM)),
        .i_addr  (lsu.lsu_addr[c_dmem_aw+1:2]),
        .i_wdata (lsu.st_data),
        .o_rdata (w_dmem_rdata)
    );

    // MMIO registers; reset wins over a same-cycle store.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ledr   <= '0;
            r_ledg   <= '0;
            r_hex_lo <= '0;
            r_hex_hi <= '0;
            r_lcd    <= '0;
        end else if (lsu.lsu_wren) begin
            case (w_region)
                RGN_LEDR:  r_ledr   <= lsu.st_data;
                RGN_LEDG:  r_ledg   <= lsu.st_data;
                RGN_HEXLO: r_hex_lo <= lsu.st_data;
                RGN_HEXHI: r_hex_hi <= lsu.st_data;
                RGN_LCD:   r_lcd    <= lsu.st_data;
                default:   ;
            endcase
        end
    end

    always_comb begin
        w_ld_data = '0;
        case (w_region)
            RGN_DMEM:  w_ld_data = w_dmem_rdata;
            RGN_LEDR:  w_ld_data = r_ledr;
            RGN_LEDG:  w_ld_data = r_ledg;
            RGN_HEXLO: w_ld_data = r_hex_lo;
            RGN_HEXHI: w_ld_data = r_hex_hi;
            RGN_LCD:   w_ld_data = r_lcd;
            RGN_SW:    w_ld_data = i_io_sw;
            RGN_BTN:   w_ld_data = {28'b0, i_io_btn};
            RGN_SRAM:  w_ld_data = {16'b0, SRAM_DQ};
            default:   w_ld_data = '0;
        endcase
    end

    assign lsu.ld_data = w_ld_data;

    assign o_io_ledr = r_ledr;
    assign o_io_ledg = r_ledg;
    assign o_io_lcd  = r_lcd;
    assign o_io_hex0 = r_hex_lo[6:0];
    assign o_io_hex1 = r_hex_lo[14:8];
    assign o_io_hex2 = r_hex_lo[22:16];
    assign o_io_hex3 = r_hex_lo[30:24];
    assign o_io_hex4 = r_hex_hi[6:0];
    assign o_io_hex5 = r_hex_hi[14:8];
    assign o_io_hex6 = r_hex_hi[22:16];
    assign o_io_hex7 = r_hex_hi[30:24];

    // SRAM glue: purely combinational, only the low halfword is carried.
    assign w_in_sram = (w_region == RGN_SRAM);
    assign SRAM_ADDR = lsu.lsu_addr[18:1];
    assign SRAM_CE_N = ~w_in_sram;
    assign SRAM_LB_N = ~w_in_sram;
    assign SRAM_UB_N = ~w_in_sram;
    assign SRAM_WE_N = ~(w_in_sram & lsu.lsu_wren);
    assign SRAM_OE_N = ~(w_in_sram & ~lsu.lsu_wren);
    assign SRAM_DQ   = (~SRAM_WE_N) ? lsu.st_data[15:0] : 16'hzzzz;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. A vector table drives
//               the bus; expected load data goes through a scoreboard queue
//               and register outputs are compared after each edge. Hand
//               sequences cover reset priority and the SRAM window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [31:0] ledr, ledg, lcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;
    logic [15:0] sram_val;
    logic        probe_en;

    int checks   = 0;
    int failures = 0;
    logic [31:0] ld_q[$];

    always #5 clk = ~clk;

    load_store_unit_if bus ();

    // SRAM model drives the bus while output-enabled; the probe drives a
    // known pattern when neither side should own the bus.
    assign sram_dq = (!oe_n) ? sram_val : (probe_en ? 16'hC3C3 : 16'hzzzz);

    load_store_unit #(.DMEM_WORDS(4096)) dut (
        .i_clk(clk), .i_rst(rst), .lsu(bus),
        .i_io_sw(sw), .i_io_btn(btn),
        .o_io_ledr(ledr), .o_io_ledg(ledg),
        .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
        .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
        .o_io_lcd(lcd),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
        .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
    );

    typedef struct packed {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] sw;
        logic [3:0]  btn;
        logic        chk_ld;
        logic [31:0] exp_ld;
        logic [31:0] exp_ledr;
        logic [31:0] exp_ledg;
        logic [31:0] exp_hexlo;
        logic [31:0] exp_hexhi;
        logic [31:0] exp_lcd;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic ld_check(input string name);
        if (ld_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual=%08h expected=none", name, bus.ld_data);
        end else begin
            check(name, bus.ld_data, ld_q.pop_front());
        end
    endtask

    function automatic logic [31:0] hex_lo_act();
        return {1'b0, hex3, 1'b0, hex2, 1'b0, hex1, 1'b0, hex0};
    endfunction

    function automatic logic [31:0] hex_hi_act();
        return {1'b0, hex7, 1'b0, hex6, 1'b0, hex5, 1'b0, hex4};
    endfunction

    task automatic check_regs(input string tag, input logic [31:0] e_ledr, input logic [31:0] e_ledg,
                              input logic [31:0] e_hlo, input logic [31:0] e_hhi, input logic [31:0] e_lcd);
        check({tag, ".ledr"},  ledr, e_ledr);
        check({tag, ".ledg"},  ledg, e_ledg);
        check({tag, ".hexlo"}, hex_lo_act(), e_hlo);
        check({tag, ".hexhi"}, hex_hi_act(), e_hhi);
        check({tag, ".lcd"},   lcd, e_lcd);
    endtask

    function automatic vec_t mk(input logic wren, input logic [31:0] addr, input logic [31:0] st,
                                input logic [31:0] s, input logic [3:0] b, input logic chk,
                                input logic [31:0] ld, input logic [31:0] r, input logic [31:0] g,
                                input logic [31:0] hl, input logic [31:0] hh, input logic [31:0] c);
        return '{wren, addr, st, s, b, chk, ld, r, g, hl, hh, c};
    endfunction

    task automatic drive(input logic wren, input logic [31:0] addr, input logic [31:0] st);
        bus.lsu_wren = wren;
        bus.lsu_addr = addr;
        bus.st_data  = st;
    endtask

    localparam logic [31:0] L  = 32'h1234_5678;
    localparam logic [31:0] G  = 32'hCAFE_F00D;
    localparam logic [31:0] HL = 32'h0006_5B4F;
    localparam logic [31:0] HH = 32'h7F3F_0102;
    localparam logic [31:0] C  = 32'hA5A5_A5A5;
    localparam logic [31:0] SW = 32'h8765_4321;

    initial begin
        //             wren addr          st            sw  btn   chk ld            ledr ledg hexlo hexhi lcd
        vecs[0]  = mk(1, 32'h0000_0008, 32'h1111_1111, 0,  4'h0, 0, 0,             0, 0, 0,  0,  0);
        vecs[1]  = mk(1, 32'h0000_0004, 32'hDEAD_BEEF, 0,  4'h0, 0, 0,             0, 0, 0,  0,  0);
        vecs[2]  = mk(0, 32'h0000_0004, 32'h0,         0,  4'h0, 1, 32'hDEAD_BEEF, 0, 0, 0,  0,  0);
        vecs[3]  = mk(0, 32'h0000_0008, 32'h0,         0,  4'h0, 1, 32'h1111_1111, 0, 0, 0,  0,  0);
        vecs[4]  = mk(1, 32'h0000_2000, L,             0,  4'h0, 0, 0,             0, 0, 0,  0,  0);
        vecs[5]  = mk(0, 32'h0000_2000, 32'hFFFF_FFFF, 0,  4'h0, 1, L,             0, 0, 0,  0,  0);
        vecs[6]  = mk(0, 32'h0000_2000, 32'h0,         0,  4'h0, 1, L,             0, 0, 0,  0,  0);
        vecs[7]  = mk(1, 32'h0000_3FFC, 32'hAAAA_5555, 0,  4'h0, 0, 0,             0, 0, 0,  0,  0);
        vecs[8]  = mk(0, 32'h0000_3FFF, 32'h0,         0,  4'h0, 1, 32'hAAAA_5555, 0, 0, 0,  0,  0);
        vecs[9]  = mk(1, 32'h0000_4004, 32'h0BAD_BAD0, 0,  4'h0, 1, 0,             0, 0, 0,  0,  0);
        vecs[10] = mk(0, 32'h0000_0004, 32'h0,         0,  4'h0, 1, 32'hDEAD_BEEF, 0, 0, 0,  0,  0);
        vecs[11] = mk(1, 32'h0000_7000, L,             0,  4'h0, 1, 0,             L, 0, 0,  0,  0);
        vecs[12] = mk(0, 32'h0000_700C, 32'h0,         0,  4'h0, 1, L,             L, 0, 0,  0,  0);
        vecs[13] = mk(1, 32'h0000_7010, G,             0,  4'h0, 1, 0,             L, G, 0,  0,  0);
        vecs[14] = mk(1, 32'h0000_7020, HL,            0,  4'h0, 1, 0,             L, G, HL, 0,  0);
        vecs[15] = mk(1, 32'h0000_7024, HH,            0,  4'h0, 1, 0,             L, G, HL, HH, 0);
        vecs[16] = mk(0, 32'h0000_7023, 32'h0,         0,  4'h0, 1, HL,            L, G, HL, HH, 0);
        vecs[17] = mk(1, 32'h0000_7030, C,             0,  4'h0, 1, 0,             L, G, HL, HH, C);
        vecs[18] = mk(0, 32'h0000_703C, 32'h0,         0,  4'h0, 1, C,             L, G, HL, HH, C);
        vecs[19] = mk(0, 32'h0000_7800, 32'h0,         SW, 4'h0, 1, SW,            L, G, HL, HH, C);
        vecs[20] = mk(1, 32'h0000_7800, 32'hFFFF_FFFF, SW, 4'h0, 1, SW,            L, G, HL, HH, C);
        vecs[21] = mk(0, 32'h0000_7810, 32'h0,         SW, 4'hA, 1, 32'h0000_000A, L, G, HL, HH, C);
        vecs[22] = mk(1, 32'h0000_5000, 32'hFFFF_FFFF, SW, 4'hA, 1, 0,             L, G, HL, HH, C);
        vecs[23] = mk(0, 32'h0000_7040, 32'h0,         SW, 4'hA, 1, 0,             L, G, HL, HH, C);
        vecs[24] = mk(0, 32'h0000_7014, 32'h0,         SW, 4'hA, 1, G,             L, G, HL, HH, C);
        vecs[25] = mk(0, 32'h0000_7028, 32'h0,         SW, 4'hA, 1, 0,             L, G, HL, HH, C);
        vecs[26] = mk(0, 32'h0000_7820, 32'h0,         SW, 4'hA, 1, 0,             L, G, HL, HH, C);

        rst = 1'b1; sw = '0; btn = '0; sram_val = 16'h1234; probe_en = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_regs("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            drive(vecs[i].wren, vecs[i].addr, vecs[i].st);
            sw  = vecs[i].sw;
            btn = vecs[i].btn;
            if (vecs[i].chk_ld) ld_q.push_back(vecs[i].exp_ld);
            #2;
            if (vecs[i].chk_ld) ld_check($sformatf("vec%0d.ld", i));
            @(posedge clk);
            #1;
            check_regs($sformatf("vec%0d", i), vecs[i].exp_ledr, vecs[i].exp_ledg,
                       vecs[i].exp_hexlo, vecs[i].exp_hexhi, vecs[i].exp_lcd);
        end

        // Reset beats a simultaneous MMIO store; DMEM keeps its contents.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'h0000_7000, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check_regs("rst_prio", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0000_0004, 32'h0);
        ld_q.push_back(32'hDEAD_BEEF);
        #2 ld_check("dmem_kept");
        @(negedge clk);
        drive(1'b0, 32'h0000_7000, 32'h0);
        ld_q.push_back(32'h0);
        #2 ld_check("ledr_rd_after_rst");

        // SRAM store
        @(negedge clk);
        drive(1'b1, 32'h0008_0010, 32'h0000_ABCD);
        #2;
        check("sram_wr.addr", {14'b0, sram_addr}, 32'h0000_0008);
        check("sram_wr.ctl", {27'b0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'b00100);
        check("sram_wr.dq", {16'b0, sram_dq}, 32'h0000_ABCD);

        // SRAM load, model drives the bus
        @(negedge clk);
        drive(1'b0, 32'h0008_0010, 32'h0);
        ld_q.push_back(32'h0000_1234);
        #2;
        check("sram_rd.ctl", {27'b0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'b01000);
        ld_check("sram_rd.ld");

        // Top of the window
        @(negedge clk);
        sram_val = 16'hBEEF;
        drive(1'b0, 32'h000F_FFFC, 32'h0);
        ld_q.push_back(32'h0000_BEEF);
        #2;
        check("sram_top.addr", {14'b0, sram_addr}, 32'h0003_FFFE);
        check("sram_top.ce", {31'b0, ce_n}, 32'h0);
        ld_check("sram_top.ld");

        // Just outside both ends of the window
        @(negedge clk);
        drive(1'b0, 32'h0010_0000, 32'h0);
        ld_q.push_back(32'h0);
        #2;
        check("sram_above.ctl", {27'b0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'b11111);
        ld_check("sram_above.ld");
        @(negedge clk);
        drive(1'b0, 32'h0007_FFFC, 32'h0);
        ld_q.push_back(32'h0);
        #2;
        check("sram_below.ctl", {27'b0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'b11111);
        ld_check("sram_below.ld");

        // Non-window store must leave the bus undriven by the DUT
        @(negedge clk);
        probe_en = 1'b1;
        drive(1'b1, 32'h0000_5000, 32'h0000_FFFF);
        #2;
        check("nowin.ctl", {27'b0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'b11111);
        check("nowin.dq", {16'b0, sram_dq}, 32'h0000_C3C3);
        @(negedge clk);
        probe_en = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        if (ld_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", ld_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
